// File: rtl/cmd_resp_rx_ctrl.sv
// rtl/cmd_resp_rx_ctrl.sv - SD CMD-line response receiver: start-bit search, frame gating, CRC7 and framing checks
module cmd_resp_rx_ctrl #(
  parameter int SHORT_BITS = 48,
  parameter int LONG_BITS  = 136,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long_resp,
  input  logic             crc_en,
  input  logic             abort,
  input  logic             cmd_in,
  output logic             des_clear,
  output logic             des_shift_en,
  output logic [CNT_W-1:0] bit_index,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             crc_err,
  output logic             frame_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              long_q;
  logic              crc_en_q;
  logic [6:0]        crc;
  logic [TO_W-1:0]   to_cnt;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  crc_lo;
  logic [CNT_W-1:0]  field_lo;
  logic              accept;
  logic              start_bit;
  logic              timeout_hit;
  logic              last_bit;
  logic              in_crc;
  logic              in_field;

  // Frame geometry: CRC field is the 7 bits just before the end bit.
  assign last_idx = long_q ? CNT_W'(LONG_BITS - 1) : CNT_W'(SHORT_BITS - 1);
  assign crc_lo   = long_q ? CNT_W'(8) : '0;
  assign field_lo = last_idx - CNT_W'(7);

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign start_bit   = (state == WAIT_START) && !cmd_in;
  assign timeout_hit = (state == WAIT_START) && cmd_in && (to_cnt == TO_W'(TIMEOUT - 1));
  assign last_bit    = (state == RECEIVE) && (bit_index == last_idx);

  assign des_shift_en = start_bit || (state == RECEIVE);
  assign busy         = (state == WAIT_START) || (state == RECEIVE);

  // bit_index is 0 throughout WAIT_START, so the start bit falls into the short-frame CRC range.
  assign in_crc   = des_shift_en && (bit_index >= crc_lo) && (bit_index < field_lo);
  assign in_field = (state == RECEIVE) && (bit_index >= field_lo) && (bit_index < last_idx);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = WAIT_START;
      WAIT_START: begin
        if (!cmd_in)          state_next = RECEIVE;
        else if (timeout_hit) state_next = DONE;
      end
      RECEIVE:    if (last_bit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      des_clear   <= 1'b1;
      bit_index   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      crc         <= '0;
      to_cnt      <= '0;
      long_q      <= 1'b0;
      crc_en_q    <= 1'b0;
    end else begin
      state     <= state_next;
      done      <= 1'b0;
      des_clear <= (state_next == IDLE) || ((state_next == WAIT_START) && (state != WAIT_START));
      if (abort) begin
        timeout_err <= 1'b0;
        crc_err     <= 1'b0;
        frame_err   <= 1'b0;
        crc         <= '0;
        to_cnt      <= '0;
        bit_index   <= '0;
      end else if (accept) begin
        long_q      <= long_resp;
        crc_en_q    <= crc_en;
        timeout_err <= 1'b0;
        crc_err     <= 1'b0;
        frame_err   <= 1'b0;
        crc         <= '0;
        to_cnt      <= '0;
        bit_index   <= '0;
      end else begin
        if ((state == WAIT_START) && cmd_in) begin
          to_cnt <= to_cnt + TO_W'(1);
          if (timeout_hit) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end
        end
        if (des_shift_en && !last_bit) bit_index <= bit_index + CNT_W'(1);
        if (in_crc) begin
          crc <= {crc[5:0], 1'b0} ^ ({7{cmd_in ^ crc[6]}} & 7'h09);
        end else if (in_field) begin
          // Received CRC arrives MSB first: compare against crc[6], then shift the next bit up.
          if (crc_en_q && (cmd_in != crc[6])) crc_err <= 1'b1;
          crc <= {crc[5:0], 1'b0};
        end
        if ((state == RECEIVE) && (bit_index == CNT_W'(1)) && cmd_in) frame_err <= 1'b1;
        if (last_bit) begin
          done <= 1'b1;
          if (!cmd_in) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cmd_resp_rx_ctrl.md
Name: cmd_resp_rx_ctrl

Overview:
Sequences reception of an SD card response on the serial CMD line. It finds the start bit, gates a downstream bit-serial deserializer for exactly one response frame (48-bit R1/R3/R6/R7 or 136-bit R2), and runs CRC7 on the fly. It also checks the framing bits, enforces a response timeout, and reports completion and status to the command-path FSM. One instance sits between the command issue logic and the command-response deserializer.

Parameters:
SHORT_BITS, 48, frame length of short responses.
LONG_BITS, 136, frame length of R2 responses.
TIMEOUT, 64, max clk cycles from arm to start bit (NCR limit).
CNT_W, 8, width of bit counter; must satisfy 2^CNT_W > LONG_BITS.

Ports:
clk  in  1  SD card clock; all logic on posedge.
reset  in  1  synchronous, active-high; clears all state.
start  in  1  one-cycle pulse: arm reception. Ignored unless IDLE or DONE.
long_resp  in  1  sampled with start: 1 = LONG_BITS frame, 0 = SHORT_BITS frame.
crc_en  in  1  sampled with start: 0 disables CRC check (R3).
abort  in  1  return to IDLE next cycle; no done pulse.
cmd_in  in  1  serial CMD line from card; idles high.
des_clear  out  1  registered; high in IDLE and on the cycle after start; deserializer clears out/counter.
des_shift_en  out  1  combinational; high on every cycle in which cmd_in is a frame bit the deserializer must capture.
bit_index  out  CNT_W  index of the frame bit currently on cmd_in (0 = start bit).
busy  out  1  high in WAIT_START and RECEIVE.
done  out  1  one-cycle pulse when a frame completes or times out.
timeout_err  out  1  status; valid from done until next start.
crc_err  out  1  status; same hold rule.
frame_err  out  1  status: transmission bit != 0 or end bit != 1.

Behaviour:
- Reset values: state IDLE, des_clear=1, des_shift_en=0, bit_index=0, busy=0, done=0, all err=0, CRC register=0, timers=0.
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE/DONE + start: latch long_resp and crc_en; clear err flags, CRC register and timeout counter; go to WAIT_START.
- WAIT_START, cmd_in=0: start bit seen. des_shift_en=1 and bit_index=0 this cycle; go to RECEIVE with bit_index=1.
- WAIT_START, cmd_in=1: increment timeout counter. If it reaches TIMEOUT, set timeout_err, pulse done, go to DONE. des_shift_en=0 throughout.
- RECEIVE: des_shift_en=1 every cycle; bit_index increments each cycle.
- RECEIVE, last bit (bit_index = N-1, N = frame length): go to DONE and pulse done in the same transition. Status flags are visible together with done.
- CRC7 uses polynomial x^7+x^3+1. Serial LFSR: fb = cmd_in ^ crc[6]; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).
- Short frame: CRC covers bits 0..39; bits 40..46 are compared MSB-first against the computed CRC; bit 47 is the end bit.
- Long frame: CRC covers bits 8..127; bits 128..134 are compared; bit 135 is the end bit.
- Any CRC-field mismatch sets crc_err when crc_en=1.
- Bit 1 must be 0 (transmission bit); bit N-1 must be 1. Either violation sets frame_err.
- Err flags are sticky until the next accepted start or reset.
- DONE behaves as IDLE for start, but holds the status flags. des_clear=0 in DONE so deserializer contents remain readable.
- abort in any state: go to IDLE next cycle, busy=0, no done pulse, err flags cleared. abort has priority over start.
- reset has priority over abort and start.
- start while busy is ignored.
- Simultaneous TIMEOUT expiry and start bit in the same cycle: the start bit wins, and reception proceeds.
- Latency: done is asserted on the cycle after the end bit is sampled.

Test Plan:
- Short R1, no errors: start, long_resp=0, crc_en=1, 3 idle-high cycles. Then frame bits 0x08_000001AA + golden-model CRC7 + end bit 1 -> des_shift_en high exactly 48 cycles; done pulses once; all err=0.
- CRC corruption: same frame with CRC bit 44 flipped -> crc_err=1, frame_err=0. Repeat with crc_en=0 -> crc_err=0.
- Long R2: long_resp=1, 136-bit frame (CID 0x0123…EF, golden CRC over bits 8..127) -> 136 shift cycles; bit_index reaches 135; no errors.
- Timeout: start, cmd_in held 1 -> done exactly TIMEOUT+1 cycles after start; timeout_err=1; des_shift_en never high. Start bit arriving on cycle TIMEOUT is still accepted.
- Framing: end bit driven 0 -> frame_err=1. Transmission bit driven 1 -> frame_err=1.
- Abort/reset mid-frame: abort at bit 20 -> IDLE next cycle, no done, des_clear=1. Then new start receives cleanly. Reset at bit 30 gives the same result.
